// File: rtl/ifu_fetch.sv
// Instruction fetch stage.
// Takes a PC from the PC stage, issues one outstanding read to instruction
// memory, captures the returned word and presents {inst, inst_pc} to decode.
// A redirect (flush) kills the current fetch; a response already in flight
// is absorbed by the kill register so it never reaches decode.
// Misaligned PCs bypass memory and are handed to decode with misalign set.
//
// Handshake rules (all three interfaces): a transfer happens on a rising
// edge where valid and ready are both high. A valid that has been raised is
// held with stable payload until the transfer (flush does not withdraw an
// issued memory request). The producer's valid never depends on the
// consumer's ready; pc_ready is combinational and independent of pc_valid.
module ifu_fetch #(
    parameter int unsigned          WIDTH      = 32,
    parameter logic [WIDTH-1:0]     START_ADDR = 32'h80000000,
    parameter int unsigned          INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,

    // PC stage side
    input  logic [WIDTH-1:0]  pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,

    // Instruction memory request
    output logic              imem_req_valid,
    output logic [WIDTH-1:0]  imem_req_addr,
    input  logic              imem_req_ready,

    // Instruction memory response
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,

    // Decode side
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [WIDTH-1:0]  inst_pc,
    output logic              misalign,
    input  logic              inst_ready,

    // Status / debug
    output logic [31:0]       fetch_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing held, ready for a PC
        REQ  = 2'd1,   // memory request presented
        WAIT = 2'd2,   // request accepted, awaiting response
        HOLD = 2'd3    // instruction presented to decode
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   kill;
    logic   kill_nxt;

    logic   accept;
    logic   aligned;
    logic   rsp_take;
    logic   deliver;

    assign aligned = (pc_in[1:0] == 2'b00);
    assign accept  = pc_valid && pc_ready;

    // A response is captured only when nothing has asked for it to be dropped.
    assign rsp_take = (state == WAIT) && imem_rsp_valid && !kill && !flush;

    // Decode consumes the held instruction; a same-cycle flush cancels it.
    assign deliver = (state == HOLD) && inst_ready && !flush;

    // State and kill register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // Next-state and kill logic; flush takes precedence over normal flow.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        if (flush) begin
            case (state)
                IDLE, HOLD: begin
                    state_nxt = IDLE;
                end
                REQ: begin
                    // The request cannot be withdrawn: finish it and drop
                    // whatever comes back.
                    kill_nxt = 1'b1;
                    if (imem_req_ready) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // Response lands this very cycle: drop it here.
                        state_nxt = IDLE;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = aligned ? REQ : HOLD;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            state_nxt = IDLE;
                            kill_nxt  = 1'b0;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        if (accept) begin
                            state_nxt = aligned ? REQ : HOLD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        pc_ready       = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        dbg_state      = state;
        if (!rst && !kill && !flush) begin
            pc_ready = (state == IDLE) || ((state == HOLD) && inst_ready);
        end
        imem_req_valid = (state == REQ);
        inst_valid     = (state == HOLD);
    end

    // Datapath: request address, held instruction and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req_addr <= '0;
            inst          <= '0;
            inst_pc       <= START_ADDR;
            misalign      <= 1'b0;
            fetch_cnt     <= 32'd0;
        end else begin
            if (accept) begin
                inst_pc <= pc_in;
                if (aligned) begin
                    imem_req_addr <= pc_in;
                end else begin
                    inst     <= '0;
                    misalign <= 1'b1;
                end
            end
            if (rsp_take) begin
                inst     <= imem_rsp_data;
                misalign <= 1'b0;
            end
            if (deliver) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly downstream of the 32-bit program counter register. Accepts the current PC, issues a single-outstanding read to instruction memory and captures the returned word. Presents {inst, inst_pc} to decode over a valid/ready handshake. Supports flush on redirect, including discard of an in-flight response, and flags misaligned PCs without touching memory.

Parameters:
WIDTH, 32, address/PC width in bits
START_ADDR, 32'h80000000, reset value of inst_pc; matches the PC reset vector
INST_W, 32, instruction word width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_in  in  WIDTH  PC from PC stage
pc_valid  in  1  pc_in is valid this cycle
pc_ready  out  1  fetch accepts pc_in this cycle
flush  in  1  redirect; kill current fetch and held instruction
imem_req_valid  out  1  memory read request valid
imem_req_addr  out  WIDTH  request address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  read data valid
imem_rsp_data  in  INST_W  read data
inst_valid  out  1  instruction available to decode
inst  out  INST_W  fetched instruction; 0 when misaligned
inst_pc  out  WIDTH  PC of inst
misalign  out  1  qualifies inst_valid: pc_in[1:0] != 0
inst_ready  in  1  decode consumes instruction
fetch_cnt  out  32  count of instructions delivered to decode

Behaviour:
- Reset values: state IDLE, imem_req_valid 0, imem_req_addr 0, inst_valid 0, inst 0, inst_pc START_ADDR, misalign 0, kill 0, fetch_cnt 0. Reset overrides all other inputs.
- States: IDLE, REQ, WAIT, HOLD, plus a 1-bit kill register.
- pc_ready = !kill && (state==IDLE || (state==HOLD && inst_ready)) && !flush. It is combinational and has no dependence on pc_valid.
- Accept (pc_valid && pc_ready), aligned:
  - Latch pc_in into imem_req_addr and inst_pc.
  - Next state is REQ.
- Accept, misaligned:
  - Latch inst_pc, set inst=0 and misalign=1.
  - Next state is HOLD. No memory request is issued.
- REQ:
  - imem_req_valid=1. imem_req_addr is held stable until the handshake.
  - On imem_req_ready, go to WAIT. The request is never withdrawn, even on flush.
- WAIT:
  - On imem_rsp_valid with kill=0: inst<=imem_rsp_data, misalign<=0, go to HOLD.
  - On imem_rsp_valid with kill=1: discard data, clear kill, go to IDLE.
  - Response arrives no earlier than the cycle after request acceptance. imem_rsp_valid outside WAIT is ignored.
- HOLD:
  - inst_valid=1.
  - On inst_ready: fetch_cnt+=1 (wraps at 2^32).
  - After inst_ready, go to REQ if a new aligned PC is accepted in the same cycle, go to HOLD if a new misaligned PC is accepted, else go to IDLE. This gives back-to-back throughput.
- Latency: the minimum from PC accept to inst_valid is 3 cycles (REQ 1 cycle, WAIT 1 cycle, then HOLD). One instruction per 3 cycles when memory is zero-wait.
- Flush, highest priority after reset:
  - In IDLE or HOLD: go to IDLE, inst_valid=0 next cycle. fetch_cnt does not increment even if inst_ready is high.
  - In REQ: set kill and stay in REQ until the handshake. The response is then discarded in WAIT.
  - In WAIT with imem_rsp_valid the same cycle: discard the response, go to IDLE, kill stays 0.
  - In WAIT without a response: set kill.
  - Flush while kill=1: no additional effect.
- No PC is accepted while kill=1 or flush=1.
- inst, inst_pc and misalign hold their values when not in HOLD; only inst_valid qualifies them.

Test Plan:
- Reset: assert rst 2 cycles with pc_valid=1 -> inst_pc=32'h80000000, inst_valid=0, imem_req_valid=0, fetch_cnt=0, pc_ready=0 during rst.
- Basic fetch:
  - Stimulus: pc_in=32'h80000000, imem_req_ready=1, rsp 1 cycle later data=32'h00000413, inst_ready=1.
  - Response: inst_valid on cycle 3 with inst=32'h00000413, inst_pc=32'h80000000; fetch_cnt=1.
- Back-to-back with stall:
  - Stimulus: PCs 32'h80000000, 32'h80000004. Hold inst_ready=0 for 4 cycles, imem_req_ready low 2 cycles.
  - Response: inst stable while stalled, imem_req_addr stable in REQ, second inst_pc=32'h80000004, no drop or duplicate.
- Misaligned: pc_in=32'h80000002 -> no imem_req_valid, inst_valid=1 with misalign=1, inst=0, inst_pc=32'h80000002.
- Flush in WAIT:
  - Stimulus: flush while awaiting a rsp that arrives 3 cycles later with data=32'hDEADBEEF. New PC 32'h80000100 offered meanwhile.
  - Response: 32'hDEADBEEF never presented; pc_ready=0 until the rsp. The next fetch uses 32'h80000100 and fetch_cnt is unchanged by the killed fetch.
- Flush in HOLD with inst_ready=1 same cycle -> inst_valid=0 next cycle, fetch_cnt not incremented, state IDLE.
